// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Holds the FSM state encoding and the bus transfer-size codes.
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BUS_BYTE = 2'd0;
    localparam logic [1:0] SZ_BUS_HALF = 2'd1;
    localparam logic [1:0] SZ_BUS_WORD = 2'd2;

    // Encodings 3..7 are not valid access sizes; treat them as full word.
    function automatic logic [1:0] bus_size(input logic [2:0] sz);
        return (sz >= 3'd2) ? SZ_BUS_WORD : sz[1:0];
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Memory-stage to SRAM-like data bus sequencer: one outstanding access,
// stall generation, load-data hold, and draining of flushed transactions.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic [DATA_W/8-1:0] mem_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [2:0]          data_size,
    input  logic                flush,
    input  logic                pipe_adv,
    output logic                stall,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size_o,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    state_t state;
    logic   cancel;
    logic   kill;

    // A flush landing in the completion cycle kills the result as well.
    assign kill  = cancel | flush;
    assign stall = mem_en & ~flush & (state != DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cancel      <= 1'b0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size_o <= 2'd0;
            data_addr   <= '0;
            data_wstrb  <= '0;
            data_wdata  <= '0;
            mem_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en && !flush) begin
                        data_req    <= 1'b1;
                        data_wr     <= |mem_wen;
                        data_addr   <= mem_addr;
                        data_wstrb  <= mem_wen;
                        data_wdata  <= mem_wdata;
                        data_size_o <= bus_size(data_size);
                        cancel      <= 1'b0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            cancel <= 1'b0;
                            if (kill) begin
                                state <= IDLE;
                            end else begin
                                if (!data_wr) mem_rdata <= data_rdata;
                                state <= DONE;
                            end
                        end else begin
                            cancel <= kill;
                            state  <= WAIT;
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        cancel <= 1'b0;
                        if (kill) begin
                            state <= IDLE;
                        end else begin
                            if (!data_wr) mem_rdata <= data_rdata;
                            state <= DONE;
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                DONE: begin
                    if (pipe_adv || flush) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The bus may only signal data_ok while a transaction is in flight.
    a_no_stray_data_ok: assert property (
        @(posedge clk) disable iff (!rst)
        !(data_data_ok && (state == IDLE || state == DONE))
    );

endmodule
